// File: rtl/dct_vecrot.sv
// dct_vecrot: rotates FFT samples X[k] by exp(-j*pi*k/(2N)) using an external quarter-wave cos/sin ROM.
// Optional macro DCT_VECROT_PIPE_EN adds a second product register (latency 4 instead of 3).
module dct_vecrot #(
    parameter int wDataIn  = 28,
    parameter int wCoef    = 18,
    parameter int wDataOut = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sink_valid,
    input  logic                       sink_sop,
    input  logic                       sink_eop,
    output logic                       sink_ready,
    input  logic signed [wDataIn-1:0]  sink_real,
    input  logic signed [wDataIn-1:0]  sink_imag,
    input  logic [11:0]                fftpts_in,
    output logic [10:0]                coef_addr,
    output logic                       coef_rden,
    input  logic signed [wCoef-1:0]    coef_cos,
    input  logic signed [wCoef-1:0]    coef_sin,
    output logic                       source_valid,
    output logic                       source_sop,
    output logic                       source_eop,
    input  logic                       source_ready,
    output logic signed [wDataOut-1:0] source_real,
    output logic signed [wDataOut-1:0] source_imag,
    output logic [11:0]                fftpts_out,
    output logic                       len_err
);

    localparam int WP = wDataIn + wCoef;
`ifdef DCT_VECROT_PIPE_EN
    localparam int PS = 2;
`else
    localparam int PS = 1;
`endif

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic        err;
        logic [11:0] n;
    } meta_t;

    logic en;
    logic acc;

    logic [10:0] k_q, k_d;
    logic [11:0] n_q, n_d;
    logic        in_frame_q, in_frame_d;

    logic [10:0] k_cur;
    logic [11:0] n_cur;
    logic [2:0]  shift;
    logic [11:0] n_eff;
    logic        last;
    logic        err_cur;
    meta_t       meta_d;

    assign en         = source_ready;
    assign acc        = sink_valid & en;
    assign sink_ready = source_ready;
    assign coef_rden  = en;

    // The sop sample already uses the new frame size and k=0.
    always_comb begin
        n_cur = sink_sop ? fftpts_in : n_q;
        k_cur = sink_sop ? 11'd0 : k_q;
        case (n_cur)
            12'd1024: shift = 3'd1;
            12'd512:  shift = 3'd2;
            12'd256:  shift = 3'd3;
            12'd128:  shift = 3'd4;
            12'd64:   shift = 3'd5;
            default:  shift = 3'd0;
        endcase
        n_eff     = 12'd2048 >> shift;
        last      = ({1'b0, k_cur} == (n_eff - 12'd1));
        coef_addr = k_cur << shift;
        // k_q==0 inside an open frame only happens after a wrap past N-1.
        err_cur   = (sink_sop & in_frame_q)
                  | (sink_eop & ~last)
                  | (~sink_sop & in_frame_q & (k_q == 11'd0));
    end

    always_comb begin
        k_d        = k_q;
        n_d        = n_q;
        in_frame_d = in_frame_q;
        if (acc) begin
            n_d        = n_cur;
            k_d        = (sink_eop | last) ? 11'd0 : k_cur + 11'd1;
            in_frame_d = (sink_sop | in_frame_q) & ~sink_eop;
        end
    end

    always_comb begin
        meta_d.valid = sink_valid;
        meta_d.sop   = sink_valid & sink_sop;
        meta_d.eop   = sink_valid & sink_eop;
        meta_d.err   = sink_valid & err_cur;
        meta_d.n     = n_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            n_q        <= '0;
            in_frame_q <= 1'b0;
        end else begin
            k_q        <= k_d;
            n_q        <= n_d;
            in_frame_q <= in_frame_d;
        end
    end

    // S1 data/meta, product stage(s), then sum/difference into the output registers.
    logic signed [wDataIn-1:0]  xr_q, xi_q;
    meta_t                      meta_q [PS+1];
    logic signed [WP-1:0]       p_rc_q [PS];
    logic signed [WP-1:0]       p_is_q [PS];
    logic signed [WP-1:0]       p_ic_q [PS];
    logic signed [WP-1:0]       p_rs_q [PS];
    logic signed [WP-1:0]       m_rc, m_is, m_ic, m_rs;
    logic signed [wDataOut-1:0] re_d, im_d;

    meta_t                      out_q;
    logic signed [wDataOut-1:0] re_q, im_q;

    assign m_rc = xr_q * coef_cos;
    assign m_is = xi_q * coef_sin;
    assign m_ic = xi_q * coef_cos;
    assign m_rs = xr_q * coef_sin;

    assign re_d = wDataOut'(p_rc_q[PS-1]) + wDataOut'(p_is_q[PS-1]);
    assign im_d = wDataOut'(p_ic_q[PS-1]) - wDataOut'(p_rs_q[PS-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr_q  <= '0;
            xi_q  <= '0;
            out_q <= '0;
            re_q  <= '0;
            im_q  <= '0;
            for (int i = 0; i <= PS; i++) begin
                meta_q[i] <= '0;
            end
            for (int i = 0; i < PS; i++) begin
                p_rc_q[i] <= '0;
                p_is_q[i] <= '0;
                p_ic_q[i] <= '0;
                p_rs_q[i] <= '0;
            end
        end else if (en) begin
            xr_q      <= sink_real;
            xi_q      <= sink_imag;
            meta_q[0] <= meta_d;
            p_rc_q[0] <= m_rc;
            p_is_q[0] <= m_is;
            p_ic_q[0] <= m_ic;
            p_rs_q[0] <= m_rs;
            for (int i = 1; i < PS; i++) begin
                p_rc_q[i] <= p_rc_q[i-1];
                p_is_q[i] <= p_is_q[i-1];
                p_ic_q[i] <= p_ic_q[i-1];
                p_rs_q[i] <= p_rs_q[i-1];
            end
            for (int i = 1; i <= PS; i++) begin
                meta_q[i] <= meta_q[i-1];
            end
            out_q <= meta_q[PS];
            re_q  <= re_d;
            im_q  <= im_d;
        end
    end

    assign source_valid = out_q.valid;
    assign source_sop   = out_q.sop;
    assign source_eop   = out_q.eop;
    assign len_err      = out_q.err;
    assign fftpts_out   = out_q.n;
    assign source_real  = re_q;
    assign source_imag  = im_q;

endmodule

// File: tb/tb_dct_vecrot.sv
// Directed bench for dct_vecrot: quarter-wave ROM model plus a queue scoreboard of expected outputs.
module tb_dct_vecrot;

    logic               clk;
    logic               rst_n;
    logic               sink_valid, sink_sop, sink_eop, sink_ready;
    logic signed [27:0] sink_real, sink_imag;
    logic [11:0]        fftpts_in;
    logic [10:0]        coef_addr;
    logic               coef_rden;
    logic signed [17:0] coef_cos, coef_sin;
    logic               source_valid, source_sop, source_eop, source_ready;
    logic signed [47:0] source_real, source_imag;
    logic [11:0]        fftpts_out;
    logic               len_err;

    dct_vecrot dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(sink_ready), .sink_real(sink_real), .sink_imag(sink_imag),
        .fftpts_in(fftpts_in), .coef_addr(coef_addr), .coef_rden(coef_rden),
        .coef_cos(coef_cos), .coef_sin(coef_sin),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_ready(source_ready), .source_real(source_real), .source_imag(source_imag),
        .fftpts_out(fftpts_out), .len_err(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cos_tab [2048];
    int sin_tab [2048];

    // Registered ROM, one enabled cycle of latency.
    initial begin
        coef_cos = '0;
        coef_sin = '0;
    end
    always @(posedge clk) begin
        if (coef_rden) begin
            coef_cos <= 18'(cos_tab[coef_addr]);
            coef_sin <= 18'(sin_tab[coef_addr]);
        end
    end

    typedef struct {
        logic signed [47:0] re;
        logic signed [47:0] im;
        logic               sop;
        logic               eop;
        logic               err;
        logic [11:0]        n;
    } exp_t;

    exp_t sb [$];

    int          vectors     = 0;
    int          miscompares = 0;
    int          m_pos       = 0;
    bit          m_inframe   = 1'b0;
    logic [11:0] m_n         = '0;

    logic signed [47:0] out_re  [2048];
    logic signed [47:0] out_im  [2048];
    logic               out_sop [2048];
    logic               out_eop [2048];
    logic               out_err [2048];
    int                 out_idx = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int shift_of(input logic [11:0] n);
        case (n)
            12'd2048: return 0;
            12'd1024: return 1;
            12'd512:  return 2;
            12'd256:  return 3;
            12'd128:  return 4;
            12'd64:   return 5;
            default:  return 0;
        endcase
    endfunction

    // One clock: drive inputs, model accepted samples, then compare whatever the enabled edge produced.
    task automatic cycle(input bit v, input bit sp, input bit ep,
                         input logic signed [27:0] re, input logic signed [27:0] im,
                         input logic [11:0] n, input bit rdy);
        exp_t        e;
        logic [11:0] n_use;
        int          sh, neff, k, addr;
        longint      pr, pi;
        sink_valid   = v;
        sink_sop     = sp;
        sink_eop     = ep;
        sink_real    = re;
        sink_imag    = im;
        fftpts_in    = n;
        source_ready = rdy;
        #1;
        if (v && rdy) begin
            n_use = sp ? n : m_n;
            sh    = shift_of(n_use);
            neff  = 2048 >> sh;
            k     = sp ? 0 : (m_pos % neff);
            addr  = (k << sh) % 2048;
            check("coef_addr", coef_addr, addr);
            pr    = longint'(re) * cos_tab[addr] + longint'(im) * sin_tab[addr];
            pi    = longint'(im) * cos_tab[addr] - longint'(re) * sin_tab[addr];
            e.re  = pr[47:0];
            e.im  = pi[47:0];
            e.sop = sp;
            e.eop = ep;
            e.n   = n_use;
            e.err = (sp && m_inframe) || (ep && (k != neff - 1)) ||
                    (!sp && m_inframe && (m_pos % neff == 0));
            sb.push_back(e);
            if (ep) begin
                m_pos = 0; m_inframe = 1'b0;
            end else if (sp) begin
                m_pos = 1; m_inframe = 1'b1;
            end else begin
                m_pos++;
            end
            m_n = n_use;
        end
        @(posedge clk);
        #1;
        if (rdy && source_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", source_valid, 0);
            end else begin
                e = sb.pop_front();
                check("real", source_real, e.re);
                check("imag", source_imag, e.im);
                check("sop", source_sop, e.sop);
                check("eop", source_eop, e.eop);
                check("len_err", len_err, e.err);
                check("fftpts_out", fftpts_out, e.n);
                if (out_idx < 2048) begin
                    out_re[out_idx]  = source_real;
                    out_im[out_idx]  = source_imag;
                    out_sop[out_idx] = source_sop;
                    out_eop[out_idx] = source_eop;
                    out_err[out_idx] = len_err;
                end
                out_idx++;
            end
        end
        $display("t=%0t v=%0b sop=%0b eop=%0b rdy=%0b addr=%0d | out v=%0b re=%0d im=%0d err=%0b",
                 $time, v, sp, ep, rdy, coef_addr, source_valid, source_real, source_imag, len_err);
    endtask

    task automatic send(input bit sp, input bit ep, input logic signed [27:0] re,
                        input logic signed [27:0] im, input logic [11:0] n);
        cycle(1'b1, sp, ep, re, im, n, 1'b1);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic rnd_frame(input logic [11:0] n, input int len);
        for (int i = 0; i < len; i++)
            send(i == 0, i == len - 1, 28'($urandom), 28'($urandom), n);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, source_valid, 0);
        check({tag, "_sop"}, source_sop, 0);
        check({tag, "_eop"}, source_eop, 0);
        check({tag, "_real"}, source_real, 0);
        check({tag, "_imag"}, source_imag, 0);
        check({tag, "_fftpts"}, fftpts_out, 0);
        check({tag, "_len_err"}, len_err, 0);
    endtask

    logic signed [47:0] snap_re, snap_im;
    logic               snap_v;
    logic [11:0]        snap_n;

    initial begin
        for (int a = 0; a < 2048; a++) begin
            cos_tab[a] = $rtoi(65536.0 * $cos(3.14159265358979 * a / 4096.0) + 0.5);
            sin_tab[a] = $rtoi(65536.0 * $sin(3.14159265358979 * a / 4096.0) + 0.5);
        end
        rst_n = 1'b0; sink_valid = 0; sink_sop = 0; sink_eop = 0;
        sink_real = '0; sink_imag = '0; fftpts_in = '0; source_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // N=64, constant (1000,0)
        out_idx = 0;
        for (int i = 0; i < 64; i++) send(i == 0, i == 63, 28'sd1000, 28'sd0, 12'd64);
        idle(6);
        check("n64_k0_real", out_re[0], 48'sd65536000);
        check("n64_k0_imag", out_im[0], 48'sd0);
        check("n64_k32_real", out_re[32], 48'sd46341000);
        check("n64_k32_imag", out_im[32], -48'sd46341000);
        check("n64_sop0", out_sop[0], 1);
        check("n64_eop63", out_eop[63], 1);
        check("n64_count", out_idx, 64);

        // N=2048 with (0,1000) at k=1024
        out_idx = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i == 1024) send(1'b0, 1'b0, 28'sd0, 28'sd1000, 12'd2048);
            else send(i == 0, i == 2047, 28'($urandom), 28'($urandom), 12'd2048);
        end
        idle(6);
        check("n2048_k1024_real", out_re[1024], 48'sd46341000);
        check("n2048_k1024_imag", out_im[1024], 48'sd46341000);

        // N=256 with a 5-cycle ready stall mid-frame
        for (int i = 0; i < 256; i++) begin
            if (i == 100) begin
                snap_re = source_real; snap_im = source_imag;
                snap_v = source_valid; snap_n = fftpts_out;
                for (int j = 0; j < 5; j++) begin
                    cycle(1'b1, 1'b0, 1'b0, 28'($urandom), 28'($urandom), 12'd256, 1'b0);
                    check("stall_sink_ready", sink_ready, 0);
                    check("stall_real", source_real, snap_re);
                    check("stall_imag", source_imag, snap_im);
                    check("stall_valid", source_valid, snap_v);
                    check("stall_fftpts", fftpts_out, snap_n);
                end
            end
            send(i == 0, i == 255, 28'($urandom), 28'($urandom), 12'd256);
        end
        idle(6);

        // N=128 with a new sop at k=10
        out_idx = 0;
        for (int i = 0; i < 10; i++) send(i == 0, 1'b0, 28'($urandom), 28'($urandom), 12'd128);
        rnd_frame(12'd128, 128);
        idle(6);
        check("resop_err", out_err[10], 1);
        check("resop_sop", out_sop[10], 1);
        check("resop_tail_err", out_err[137], 0);

        // fftpts=300 addresses like N=2048; short frame ends in an eop error
        out_idx = 0;
        rnd_frame(12'd300, 40);
        idle(6);
        check("n300_eop_err", out_err[39], 1);

        // Overrun of an N=64 frame, then back-to-back frames with bubbles
        rnd_frame(12'd64, 66);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(i == 0, i == 63, 28'($urandom), 28'($urandom), 12'd512 >> f);
            end
        rnd_frame(12'd64, 64);
        rnd_frame(12'd64, 64);
        idle(6);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 20; i++) send(i == 0, 1'b0, 28'($urandom), 28'($urandom), 12'd64);
        sink_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        m_pos = 0; m_inframe = 1'b0; m_n = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_idx = 0;
        rnd_frame(12'd64, 64);
        idle(6);
        check("post_rst_count", out_idx, 64);
        check("post_rst_err", out_err[0], 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
